// File: rtl/pipeline_registers.sv
// rtl/pipeline_registers.sv - IF/ID, ID/EX and EX/MEM register banks of the RV32IM pipeline
// Shared stall holds every bank; flush turns IF/ID and ID/EX into bubbles.
module pipeline_registers (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  // IF/ID
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_INSTRUCTION,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_INSTRUCTION,
  // ID/EX
  input  logic [31:0] ID_PC_IN,
  input  logic [31:0] ID_REG_DATA1,
  input  logic [31:0] ID_REG_DATA2,
  input  logic [31:0] ID_IMMEDIATE,
  input  logic [4:0]  ID_REG_WRITE_ADDR,
  input  logic [3:0]  ID_BRANCH_SEL,
  input  logic [4:0]  ID_ALU_SEL,
  input  logic        ID_OPERAND1_SEL,
  input  logic        ID_OPERAND2_SEL,
  input  logic [2:0]  ID_MEM_WRITE,
  input  logic [3:0]  ID_MEM_READ,
  input  logic        ID_REG_WRITE_EN,
  input  logic [1:0]  ID_REG_WRITE_SEL,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_REG_DATA1,
  output logic [31:0] EX_REG_DATA2,
  output logic [31:0] EX_IMMEDIATE,
  output logic [4:0]  EX_REG_WRITE_ADDR,
  output logic [3:0]  EX_BRANCH_SEL,
  output logic [4:0]  EX_ALU_SEL,
  output logic        EX_OPERAND1_SEL,
  output logic        EX_OPERAND2_SEL,
  output logic [2:0]  EX_MEM_WRITE,
  output logic [3:0]  EX_MEM_READ,
  output logic        EX_REG_WRITE_EN,
  output logic [1:0]  EX_REG_WRITE_SEL,
  // EX/MEM
  input  logic [31:0] EX_PC_IN,
  input  logic [31:0] EX_ALU_OUT,
  input  logic [31:0] EX_REG_DATA2_IN,
  input  logic [4:0]  EX_REG_WRITE_ADDR_IN,
  input  logic        EX_REG_WRITE_EN_IN,
  input  logic [2:0]  EX_MEM_WRITE_IN,
  input  logic [3:0]  EX_MEM_READ_IN,
  input  logic [1:0]  EX_REG_WRITE_SEL_IN,
  output logic [31:0] MEM_PC,
  output logic [31:0] MEM_ALU_OUT,
  output logic [31:0] MEM_REG_DATA2,
  output logic [4:0]  MEM_REG_WRITE_ADDR,
  output logic        MEM_REG_WRITE_EN,
  output logic [2:0]  MEM_MEM_WRITE,
  output logic [3:0]  MEM_MEM_READ,
  output logic [1:0]  MEM_REG_WRITE_SEL
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] immediate;
    logic [4:0]  reg_write_addr;
    logic [3:0]  branch_sel;
    logic [4:0]  alu_sel;
    logic        operand1_sel;
    logic        operand2_sel;
    logic [2:0]  mem_write;
    logic [3:0]  mem_read;
    logic        reg_write_en;
    logic [1:0]  reg_write_sel;
  } idex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] reg_data2;
    logic [4:0]  reg_write_addr;
    logic        reg_write_en;
    logic [2:0]  mem_write;
    logic [3:0]  mem_read;
    logic [1:0]  reg_write_sel;
  } exmem_t;

  ifid_t  ifid_q,  ifid_d,  ifid_in;
  idex_t  idex_q,  idex_d,  idex_in;
  exmem_t exmem_q, exmem_d, exmem_in;

  always_comb begin
    ifid_in.pc    = IF_PC;
    ifid_in.instr = IF_INSTRUCTION;

    idex_in.pc             = ID_PC_IN;
    idex_in.reg_data1      = ID_REG_DATA1;
    idex_in.reg_data2      = ID_REG_DATA2;
    idex_in.immediate      = ID_IMMEDIATE;
    idex_in.reg_write_addr = ID_REG_WRITE_ADDR;
    idex_in.branch_sel     = ID_BRANCH_SEL;
    idex_in.alu_sel        = ID_ALU_SEL;
    idex_in.operand1_sel   = ID_OPERAND1_SEL;
    idex_in.operand2_sel   = ID_OPERAND2_SEL;
    idex_in.mem_write      = ID_MEM_WRITE;
    idex_in.mem_read       = ID_MEM_READ;
    idex_in.reg_write_en   = ID_REG_WRITE_EN;
    idex_in.reg_write_sel  = ID_REG_WRITE_SEL;

    exmem_in.pc             = EX_PC_IN;
    exmem_in.alu_out        = EX_ALU_OUT;
    exmem_in.reg_data2      = EX_REG_DATA2_IN;
    exmem_in.reg_write_addr = EX_REG_WRITE_ADDR_IN;
    exmem_in.reg_write_en   = EX_REG_WRITE_EN_IN;
    exmem_in.mem_write      = EX_MEM_WRITE_IN;
    exmem_in.mem_read       = EX_MEM_READ_IN;
    exmem_in.reg_write_sel  = EX_REG_WRITE_SEL_IN;
  end

  // Stall outranks flush; EX/MEM ignores flush so the branch itself retires.
  always_comb begin
    ifid_d  = ifid_q;
    idex_d  = idex_q;
    exmem_d = exmem_q;
    if (!STALL) begin
      if (FLUSH) begin
        ifid_d.pc    = 32'h0;
        ifid_d.instr = NOP_INSTR;
        idex_d       = '0;
      end else begin
        ifid_d = ifid_in;
        idex_d = idex_in;
      end
      exmem_d = exmem_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ifid_q.pc    <= 32'h0;
      ifid_q.instr <= NOP_INSTR;
      idex_q       <= '0;
      exmem_q      <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign ID_PC          = ifid_q.pc;
  assign ID_INSTRUCTION = ifid_q.instr;

  assign EX_PC             = idex_q.pc;
  assign EX_REG_DATA1      = idex_q.reg_data1;
  assign EX_REG_DATA2      = idex_q.reg_data2;
  assign EX_IMMEDIATE      = idex_q.immediate;
  assign EX_REG_WRITE_ADDR = idex_q.reg_write_addr;
  assign EX_BRANCH_SEL     = idex_q.branch_sel;
  assign EX_ALU_SEL        = idex_q.alu_sel;
  assign EX_OPERAND1_SEL   = idex_q.operand1_sel;
  assign EX_OPERAND2_SEL   = idex_q.operand2_sel;
  assign EX_MEM_WRITE      = idex_q.mem_write;
  assign EX_MEM_READ       = idex_q.mem_read;
  assign EX_REG_WRITE_EN   = idex_q.reg_write_en;
  assign EX_REG_WRITE_SEL  = idex_q.reg_write_sel;

  assign MEM_PC             = exmem_q.pc;
  assign MEM_ALU_OUT        = exmem_q.alu_out;
  assign MEM_REG_DATA2      = exmem_q.reg_data2;
  assign MEM_REG_WRITE_ADDR = exmem_q.reg_write_addr;
  assign MEM_REG_WRITE_EN   = exmem_q.reg_write_en;
  assign MEM_MEM_WRITE      = exmem_q.mem_write;
  assign MEM_MEM_READ       = exmem_q.mem_read;
  assign MEM_REG_WRITE_SEL  = exmem_q.reg_write_sel;

endmodule

// File: tb/tb_pipeline_registers.sv
// tb/tb_pipeline_registers.sv - directed checks of the pipeline register banks
module tb_pipeline_registers;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH;
  logic [31:0] IF_PC, IF_INSTRUCTION, ID_PC, ID_INSTRUCTION;
  logic [31:0] ID_PC_IN, ID_REG_DATA1, ID_REG_DATA2, ID_IMMEDIATE;
  logic [4:0]  ID_REG_WRITE_ADDR, ID_ALU_SEL;
  logic [3:0]  ID_BRANCH_SEL, ID_MEM_READ;
  logic        ID_OPERAND1_SEL, ID_OPERAND2_SEL, ID_REG_WRITE_EN;
  logic [2:0]  ID_MEM_WRITE;
  logic [1:0]  ID_REG_WRITE_SEL;
  logic [31:0] EX_PC, EX_REG_DATA1, EX_REG_DATA2, EX_IMMEDIATE;
  logic [4:0]  EX_REG_WRITE_ADDR, EX_ALU_SEL;
  logic [3:0]  EX_BRANCH_SEL, EX_MEM_READ;
  logic        EX_OPERAND1_SEL, EX_OPERAND2_SEL, EX_REG_WRITE_EN;
  logic [2:0]  EX_MEM_WRITE;
  logic [1:0]  EX_REG_WRITE_SEL;
  logic [31:0] EX_PC_IN, EX_ALU_OUT, EX_REG_DATA2_IN;
  logic [4:0]  EX_REG_WRITE_ADDR_IN;
  logic        EX_REG_WRITE_EN_IN;
  logic [2:0]  EX_MEM_WRITE_IN;
  logic [3:0]  EX_MEM_READ_IN;
  logic [1:0]  EX_REG_WRITE_SEL_IN;
  logic [31:0] MEM_PC, MEM_ALU_OUT, MEM_REG_DATA2;
  logic [4:0]  MEM_REG_WRITE_ADDR;
  logic        MEM_REG_WRITE_EN;
  logic [2:0]  MEM_MEM_WRITE;
  logic [3:0]  MEM_MEM_READ;
  logic [1:0]  MEM_REG_WRITE_SEL;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  pipeline_registers dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .IF_PC(IF_PC), .IF_INSTRUCTION(IF_INSTRUCTION),
    .ID_PC(ID_PC), .ID_INSTRUCTION(ID_INSTRUCTION),
    .ID_PC_IN(ID_PC_IN), .ID_REG_DATA1(ID_REG_DATA1), .ID_REG_DATA2(ID_REG_DATA2),
    .ID_IMMEDIATE(ID_IMMEDIATE), .ID_REG_WRITE_ADDR(ID_REG_WRITE_ADDR),
    .ID_BRANCH_SEL(ID_BRANCH_SEL), .ID_ALU_SEL(ID_ALU_SEL),
    .ID_OPERAND1_SEL(ID_OPERAND1_SEL), .ID_OPERAND2_SEL(ID_OPERAND2_SEL),
    .ID_MEM_WRITE(ID_MEM_WRITE), .ID_MEM_READ(ID_MEM_READ),
    .ID_REG_WRITE_EN(ID_REG_WRITE_EN), .ID_REG_WRITE_SEL(ID_REG_WRITE_SEL),
    .EX_PC(EX_PC), .EX_REG_DATA1(EX_REG_DATA1), .EX_REG_DATA2(EX_REG_DATA2),
    .EX_IMMEDIATE(EX_IMMEDIATE), .EX_REG_WRITE_ADDR(EX_REG_WRITE_ADDR),
    .EX_BRANCH_SEL(EX_BRANCH_SEL), .EX_ALU_SEL(EX_ALU_SEL),
    .EX_OPERAND1_SEL(EX_OPERAND1_SEL), .EX_OPERAND2_SEL(EX_OPERAND2_SEL),
    .EX_MEM_WRITE(EX_MEM_WRITE), .EX_MEM_READ(EX_MEM_READ),
    .EX_REG_WRITE_EN(EX_REG_WRITE_EN), .EX_REG_WRITE_SEL(EX_REG_WRITE_SEL),
    .EX_PC_IN(EX_PC_IN), .EX_ALU_OUT(EX_ALU_OUT), .EX_REG_DATA2_IN(EX_REG_DATA2_IN),
    .EX_REG_WRITE_ADDR_IN(EX_REG_WRITE_ADDR_IN), .EX_REG_WRITE_EN_IN(EX_REG_WRITE_EN_IN),
    .EX_MEM_WRITE_IN(EX_MEM_WRITE_IN), .EX_MEM_READ_IN(EX_MEM_READ_IN),
    .EX_REG_WRITE_SEL_IN(EX_REG_WRITE_SEL_IN),
    .MEM_PC(MEM_PC), .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2),
    .MEM_REG_WRITE_ADDR(MEM_REG_WRITE_ADDR), .MEM_REG_WRITE_EN(MEM_REG_WRITE_EN),
    .MEM_MEM_WRITE(MEM_MEM_WRITE), .MEM_MEM_READ(MEM_MEM_READ),
    .MEM_REG_WRITE_SEL(MEM_REG_WRITE_SEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Every input field is a distinct slice/offset of one base word.
  task automatic drive(input logic [31:0] b);
    IF_PC = b; IF_INSTRUCTION = b ^ 32'h1111_1111;
    ID_PC_IN = b + 1; ID_REG_DATA1 = b + 2; ID_REG_DATA2 = b + 3; ID_IMMEDIATE = b + 4;
    ID_BRANCH_SEL = b[3:0]; ID_ALU_SEL = b[8:4]; ID_OPERAND1_SEL = b[9];
    ID_OPERAND2_SEL = b[10]; ID_MEM_WRITE = b[13:11]; ID_MEM_READ = b[17:14];
    ID_REG_WRITE_EN = b[18]; ID_REG_WRITE_SEL = b[20:19]; ID_REG_WRITE_ADDR = b[25:21];
    EX_PC_IN = b + 5; EX_ALU_OUT = b + 6; EX_REG_DATA2_IN = b + 7;
    EX_REG_WRITE_ADDR_IN = b[30:26]; EX_REG_WRITE_EN_IN = b[31];
    EX_MEM_WRITE_IN = b[2:0]; EX_MEM_READ_IN = b[7:4]; EX_REG_WRITE_SEL_IN = b[9:8];
  endtask

  task automatic chk_ifid(input logic [31:0] b);
    chk("id_pc", ID_PC, b);
    chk("id_instr", ID_INSTRUCTION, b ^ 32'h1111_1111);
  endtask

  task automatic chk_idex(input logic [31:0] b);
    chk("ex_pc", EX_PC, b + 1);
    chk("ex_rd1", EX_REG_DATA1, b + 2);
    chk("ex_rd2", EX_REG_DATA2, b + 3);
    chk("ex_imm", EX_IMMEDIATE, b + 4);
    chk("ex_br", {28'h0, EX_BRANCH_SEL}, {28'h0, b[3:0]});
    chk("ex_alu", {27'h0, EX_ALU_SEL}, {27'h0, b[8:4]});
    chk("ex_op1", {31'h0, EX_OPERAND1_SEL}, {31'h0, b[9]});
    chk("ex_op2", {31'h0, EX_OPERAND2_SEL}, {31'h0, b[10]});
    chk("ex_mw", {29'h0, EX_MEM_WRITE}, {29'h0, b[13:11]});
    chk("ex_mr", {28'h0, EX_MEM_READ}, {28'h0, b[17:14]});
    chk("ex_rwe", {31'h0, EX_REG_WRITE_EN}, {31'h0, b[18]});
    chk("ex_rws", {30'h0, EX_REG_WRITE_SEL}, {30'h0, b[20:19]});
    chk("ex_rd", {27'h0, EX_REG_WRITE_ADDR}, {27'h0, b[25:21]});
  endtask

  task automatic chk_exmem(input logic [31:0] b);
    chk("mem_pc", MEM_PC, b + 5);
    chk("mem_alu", MEM_ALU_OUT, b + 6);
    chk("mem_rd2", MEM_REG_DATA2, b + 7);
    chk("mem_rd", {27'h0, MEM_REG_WRITE_ADDR}, {27'h0, b[30:26]});
    chk("mem_rwe", {31'h0, MEM_REG_WRITE_EN}, {31'h0, b[31]});
    chk("mem_mw", {29'h0, MEM_MEM_WRITE}, {29'h0, b[2:0]});
    chk("mem_mr", {28'h0, MEM_MEM_READ}, {28'h0, b[7:4]});
    chk("mem_rws", {30'h0, MEM_REG_WRITE_SEL}, {30'h0, b[9:8]});
  endtask

  task automatic chk_ifid_bubble();
    chk("id_pc_bub", ID_PC, 32'h0);
    chk("id_instr_nop", ID_INSTRUCTION, 32'h0000_0013);
  endtask

  task automatic chk_idex_zero();
    chk("ex_zero_pc", EX_PC, 32'h0);
    chk("ex_zero_rd1", EX_REG_DATA1, 32'h0);
    chk("ex_zero_rd2", EX_REG_DATA2, 32'h0);
    chk("ex_zero_imm", EX_IMMEDIATE, 32'h0);
    chk("ex_zero_ctl", {EX_REG_WRITE_ADDR, EX_BRANCH_SEL, EX_ALU_SEL, EX_OPERAND1_SEL,
                        EX_OPERAND2_SEL, EX_MEM_WRITE, EX_MEM_READ, EX_REG_WRITE_EN,
                        EX_REG_WRITE_SEL}, 32'h0);
  endtask

  task automatic chk_exmem_zero();
    chk("mem_zero_pc", MEM_PC, 32'h0);
    chk("mem_zero_alu", MEM_ALU_OUT, 32'h0);
    chk("mem_zero_rd2", MEM_REG_DATA2, 32'h0);
    chk("mem_zero_ctl", {17'h0, MEM_REG_WRITE_ADDR, MEM_REG_WRITE_EN, MEM_MEM_WRITE,
                         MEM_MEM_READ, MEM_REG_WRITE_SEL}, 32'h0);
  endtask

  task automatic chk_reset();
    chk_ifid_bubble();
    chk_idex_zero();
    chk_exmem_zero();
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    drive(32'hDEAD_BEEF);
    IF_INSTRUCTION = 32'hDEAD_BEEF;

    // Reset with arbitrary inputs
    step();
    chk_reset();

    // First edge out of reset loads every bank
    RESET = 1'b0;
    drive(32'h1234_5678);
    step();
    chk_ifid(32'h1234_5678);
    chk_idex(32'h1234_5678);
    chk_exmem(32'h1234_5678);

    // Named fetch/decode vector
    drive(32'h0000_0010);
    IF_INSTRUCTION = 32'h00A0_0093;
    ID_ALU_SEL = 5'h3; ID_REG_WRITE_EN = 1'b1; ID_REG_WRITE_ADDR = 5'd1;
    EX_ALU_OUT = 32'hFFFF_FFFF;
    step();
    chk("id_pc_10", ID_PC, 32'h0000_0010);
    chk("id_instr_addi", ID_INSTRUCTION, 32'h00A0_0093);
    chk("ex_alu_3", {27'h0, EX_ALU_SEL}, 32'h3);
    chk("ex_rwe_1", {31'h0, EX_REG_WRITE_EN}, 32'h1);
    chk("ex_rd_1", {27'h0, EX_REG_WRITE_ADDR}, 32'h1);
    chk("mem_alu_ones", MEM_ALU_OUT, 32'hFFFF_FFFF);

    // All-ones-ish pattern, EX_ALU_OUT = 0xFFFFFFFF via base+6
    drive(32'hFFFF_FFF9);
    step();
    chk_ifid(32'hFFFF_FFF9);
    chk_idex(32'hFFFF_FFF9);
    chk_exmem(32'hFFFF_FFF9);

    // Stall three edges while inputs change
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0F0F_0000 + 32'(i) * 32'h0101_0101);
      step();
      chk_ifid(32'hFFFF_FFF9);
      chk_idex(32'hFFFF_FFF9);
      chk_exmem(32'hFFFF_FFF9);
    end
    STALL = 1'b0;
    drive(32'hA5C3_5A3C);
    step();
    chk_ifid(32'hA5C3_5A3C);
    chk_idex(32'hA5C3_5A3C);
    chk_exmem(32'hA5C3_5A3C);

    // Flush bubbles IF/ID and ID/EX, EX/MEM still loads
    drive(32'h6B2D_91E7);
    ID_MEM_WRITE = 3'b010; ID_REG_WRITE_EN = 1'b1;
    FLUSH = 1'b1;
    step();
    chk_ifid_bubble();
    chk_idex_zero();
    chk_exmem(32'h6B2D_91E7);
    FLUSH = 1'b0;

    // Stall outranks flush
    drive(32'h3C96_7E15);
    step();
    chk_idex(32'h3C96_7E15);
    STALL = 1'b1; FLUSH = 1'b1;
    drive(32'h5555_AAAA);
    step();
    chk_ifid(32'h3C96_7E15);
    chk_idex(32'h3C96_7E15);
    chk_exmem(32'h3C96_7E15);

    // Reset outranks stall and flush
    RESET = 1'b1;
    step();
    chk_reset();
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;

    // Reset in a full pipeline, then resume
    drive(32'h9E37_79B9);
    step();
    chk_exmem(32'h9E37_79B9);
    drive(32'h7F4A_7C15);
    RESET = 1'b1;
    step();
    chk_reset();
    RESET = 1'b0;
    step();
    chk_ifid(32'h7F4A_7C15);
    chk_idex(32'h7F4A_7C15);
    chk_exmem(32'h7F4A_7C15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_registers.md
# pipeline_registers

Bundles the three inter-stage register banks of the RV32IM five-stage pipeline: IF/ID, ID/EX and EX/MEM. Each bank captures its stage's datapath values and control signals on the rising clock edge and presents them to the next stage for one cycle. A common stall input holds all banks during memory busy-wait. A flush input inserts a bubble into IF/ID and ID/EX on a taken branch or jump.

## Interface
- No parameters; data width fixed at 32, register address 5.
- CLK  in  1  rising-edge clock, the only clock
- RESET  in  1  synchronous, active-high; clears all banks
- STALL  in  1  hold every bank (driven by instruction- or data-memory busy-wait)
- FLUSH  in  1  taken branch/jump resolved in EX; bubble IF/ID and ID/EX
- IF_PC, IF_INSTRUCTION  in  32 each  fetch-stage PC and instruction word
- ID_PC, ID_INSTRUCTION  out  32 each  IF/ID contents
- ID_PC_IN, ID_REG_DATA1, ID_REG_DATA2, ID_IMMEDIATE  in  32 each  decode-stage values
- ID_REG_WRITE_ADDR  in  5  destination register (rd)
- ID_BRANCH_SEL 4, ID_ALU_SEL 5, ID_OPERAND1_SEL 1, ID_OPERAND2_SEL 1, ID_MEM_WRITE 3, ID_MEM_READ 4, ID_REG_WRITE_EN 1, ID_REG_WRITE_SEL 2  in  decode-stage control fields
- EX_PC, EX_REG_DATA1, EX_REG_DATA2, EX_IMMEDIATE  out  32 each; EX_REG_WRITE_ADDR out 5; EX_BRANCH_SEL, EX_ALU_SEL, EX_OPERAND1_SEL, EX_OPERAND2_SEL, EX_MEM_WRITE, EX_MEM_READ, EX_REG_WRITE_EN, EX_REG_WRITE_SEL  out  same widths as ID_ counterparts
- EX_PC_IN, EX_ALU_OUT, EX_REG_DATA2_IN  in  32 each; EX_REG_WRITE_ADDR_IN in 5; EX_REG_WRITE_EN_IN 1, EX_MEM_WRITE_IN 3, EX_MEM_READ_IN 4, EX_REG_WRITE_SEL_IN 2  in
- MEM_PC, MEM_ALU_OUT, MEM_REG_DATA2  out  32 each; MEM_REG_WRITE_ADDR out 5; MEM_REG_WRITE_EN 1, MEM_MEM_WRITE 3, MEM_MEM_READ 4, MEM_REG_WRITE_SEL 2  out

## Operation
- Every output is a flop; no combinational path from any input to any output.
- Per bank, per rising CLK edge, priority: RESET > STALL > FLUSH > load.
- RESET: all outputs zero, except ID_INSTRUCTION = 0x00000013 (addi x0,x0,0).
- STALL=1 (RESET=0): all three banks hold their values; FLUSH is ignored that edge.
- FLUSH=1, STALL=0:
  - IF/ID loads ID_INSTRUCTION=0x00000013 and ID_PC=0.
  - ID/EX loads all-zero (bubble).
  - EX/MEM loads normally, so the branching instruction itself proceeds.
- Load: each output takes its corresponding input unchanged, with no masking or extension.
- A zero control word (reg_write_EN=0, mem_read=0, mem_write=0, branch_sel=0) is a true bubble: no register write, memory access or branch.

## Timing
- Latency 1 cycle per bank. An instruction fetched at edge n is in ID after edge n, in EX after edge n+1, and in MEM after edge n+2.
- Outputs change only after a rising CLK edge. Inputs must be stable setup-before the edge.
- RESET asserted mid-stream clears all banks at that edge, regardless of STALL or FLUSH. The first valid instruction is captured on the first edge with RESET=0.
- STALL held for k cycles freezes all outputs for k edges. Loading resumes on the first edge with STALL=0.
- FLUSH pulsed 1 cycle removes exactly the two younger instructions, those in IF/ID and ID/EX.

## Test plan
- Reset: RESET=1 for one edge with arbitrary inputs, e.g. IF_INSTRUCTION=0xDEADBEEF -> ID_INSTRUCTION=0x00000013, every other output 0.
- Propagation: IF_PC=0x10, IF_INSTRUCTION=0x00A00093; decode inputs ALU_SEL=5'h3, REG_WRITE_EN=1, rd=1; then EX inputs -> each value appears on the next bank's outputs exactly one edge later, bit-exact, including EX_ALU_OUT=0xFFFFFFFF -> MEM_ALU_OUT=0xFFFFFFFF.
- Stall: load distinct values, assert STALL for 3 edges while changing all inputs -> outputs unchanged for 3 edges, then the new inputs are captured on the first STALL=0 edge.
- Flush: FLUSH=1 for one edge with ID_MEM_WRITE=3'b010, ID_REG_WRITE_EN=1 -> EX_MEM_WRITE=0, EX_REG_WRITE_EN=0, ID_INSTRUCTION=0x00000013, while EX/MEM still captures its inputs.
- Priority: STALL=1 with FLUSH=1 -> hold, no bubble. RESET=1 with STALL=1 -> reset values.
- Reset mid-operation: pipeline full, RESET=1 for one edge -> all banks cleared; then loading resumes normally.
